alu_req_arbiter: RTL and testbench
==================================

// Module: alu_req_arbiter
// PURPOSE
//  Shares one alu instance between two requesters and sequences its enter-driven load protocol.
//  Per accepted request, the block does the following in order:
//   - drives in_A/in_B/oper to the alu;
//   - issues the four enter pulses (A, B, oper, result);
//   - captures result and returns it to the winning requester;
//   - clears the alu through its rst.
//  Arbitration is round-robin; illegal opcodes are rejected without touching the alu.
// PARAMETERS
//  N_ENTER      4  enter pulses per operation (A, B, oper, result)
//  ENTER_HI     1  cycles alu_enter held high per pulse (>=1)
//  ENTER_LO     1  cycles alu_enter held low after each pulse (>=1)
//  RESULT_WAIT  2  cycles after the last low phase before alu_result is sampled (>=1)
//  CLR_CYCLES   4  cycles alu_rst held high after capture (>=1)
// PORTS
//  clk         in   1  system clock, rising edge
//  rst         in   1  synchronous, active-low reset
//  req0/req1   in   1  level request, held until done/err for that requester
//  a0/a1       in   4  operand A per requester
//  b0/b1       in   4  operand B per requester
//  op0/op1     in   4  alu opcode per requester (legal 4'h1..4'hE)
//  done0/done1 out  1  one-cycle pulse, res valid for that requester
//  err0/err1   out  1  one-cycle pulse, request rejected (illegal opcode)
//  res         out  8  captured alu result; held until next capture
//  busy        out  1  high in any state other than IDLE
//  alu_in_A    out  4  to alu in_A
//  alu_in_B    out  4  to alu in_B
//  alu_oper    out  4  to alu oper
//  alu_enter   out  1  to alu enter
//  alu_rst     out  1  to alu rst (active-high)
//  alu_result  in   8  from alu result
// BEHAVIOUR
//  Reset (rst low at clk edge):
//   - state=IDLE; done*, err*, busy, alu_enter = 0; res, alu_in_A/B, alu_oper = 0; alu_rst = 1.
//   - Last-grant pointer is set to 1, so req0 wins the first tie.
//   - Reset mid-operation aborts the sequence: no done/err, no result capture.
//  States: IDLE -> ENT_HI <-> ENT_LO -> WAIT -> CAPT -> CLEAR -> IDLE; IDLE -> REJ -> IDLE.
//  IDLE:
//   - alu_rst = 0.
//   - If any req is high, grant the requester not granted last time (if both high), else the single requester.
//   - On the accept edge, latch a/b/op of the winner; later input changes are ignored.
//   - If the latched op is 4'h0 or 4'hF, go to REJ; else go to ENT_HI.
//  REJ: err<winner> = 1 for one cycle, then IDLE. The alu is not driven (no enter, no alu_rst).
//  ENT_HI / ENT_LO:
//   - alu_enter = 1 for ENTER_HI cycles, then 0 for ENTER_LO cycles.
//   - A pulse counter repeats this N_ENTER times, then goes to WAIT.
//  WAIT: RESULT_WAIT cycles, alu_enter = 0.
//  CAPT: one cycle; res <= alu_result; done<winner> = 1 in the same cycle res updates.
//  CLEAR: alu_rst = 1 for CLR_CYCLES cycles, then IDLE; the pointer records the winner.
//  alu_in_A/B/alu_oper hold the latched values from the accept edge through CLEAR.
//  Latency, accept edge to done: N_ENTER*(ENTER_HI+ENTER_LO)+RESULT_WAIT+1 cycles (11 by default).
//  Requester handshake:
//   - The requester must drop req on the cycle after done/err.
//   - A req still high when the block returns to IDLE is treated as a new request.
//   - Round-robin still favours the other requester if it is pending.
//  No preemption: a req arriving while busy waits; it is never dropped.
//  Simultaneous done and new req: the new req is seen only in IDLE, after CLEAR.
//  Both requests illegal: each is rejected in turn, round-robin order.
// TESTING
//  - req0 only, a0=8, b0=2, op0=1 -> exactly 4 enter pulses; done0 11 cycles after accept; res=8'h0A; alu_rst high 4 cycles.
//  - req0 and req1 high on the same cycle, op0=3 (9*9), op1=2 (15-8) -> done0 first with res=8'h51; then done1 with res=8'h07.
//  - req1 held high across two ops while req0 rises mid-op1 -> the second grant goes to req0, not req1.
//  - req0 with op0=4'h0 (and separately 4'hF) -> err0 pulse; alu_enter and alu_rst stay 0; res unchanged.
//  - rst low during the 3rd enter pulse -> alu_enter=0 next cycle; no done0; after release, the block is in IDLE with pointer=1.
//  - RESULT_WAIT=3, ENTER_HI=2 build, AND 4'hD&4'h7 -> res=8'h05; done0 exactly 4*3+3+1=16 cycles after accept.

Source files
------------

// File: rtl/alu_req_arbiter.sv
// Round-robin front end that shares one enter-driven alu between two requesters.
// It latches the winner's operands, sequences the enter pulses, captures the result and clears the alu.
module alu_req_arbiter #(
    parameter int N_ENTER     = 4,
    parameter int ENTER_HI    = 1,
    parameter int ENTER_LO    = 1,
    parameter int RESULT_WAIT = 2,
    parameter int CLR_CYCLES  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [3:0] a0,
    input  logic [3:0] a1,
    input  logic [3:0] b0,
    input  logic [3:0] b1,
    input  logic [3:0] op0,
    input  logic [3:0] op1,
    output logic       done0,
    output logic       done1,
    output logic       err0,
    output logic       err1,
    output logic [7:0] res,
    output logic       busy,
    output logic [3:0] alu_in_A,
    output logic [3:0] alu_in_B,
    output logic [3:0] alu_oper,
    output logic       alu_enter,
    output logic       alu_rst,
    input  logic [7:0] alu_result
);

    localparam int CW = 8;

    typedef enum logic [2:0] {
        IDLE,
        REJ,
        ENT_HI,
        ENT_LO,
        WAIT,
        CAPT,
        CLEAR
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [CW-1:0] pulse;
    logic [CW-1:0] pulse_next;
    logic          winner;
    logic          last_grant;
    logic          any_req;
    logic          grant_sel;
    logic [3:0]    grant_op;
    logic          grant_illegal;

    // On a tie the requester not served last time wins; otherwise the lone requester does.
    always_comb begin
        any_req       = req0 | req1;
        grant_sel     = (req0 & req1) ? ~last_grant : req1;
        grant_op      = grant_sel ? op1 : op0;
        grant_illegal = (grant_op == 4'h0) || (grant_op == 4'hF);
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pulse_next = pulse;
        case (state)
            IDLE: begin
                cnt_next   = '0;
                pulse_next = '0;
                if (any_req) begin
                    state_next = grant_illegal ? REJ : ENT_HI;
                end
            end
            REJ: begin
                state_next = IDLE;
            end
            ENT_HI: begin
                if (cnt == CW'(ENTER_HI - 1)) begin
                    cnt_next   = '0;
                    state_next = ENT_LO;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            ENT_LO: begin
                if (cnt == CW'(ENTER_LO - 1)) begin
                    cnt_next = '0;
                    if (pulse == CW'(N_ENTER - 1)) begin
                        state_next = WAIT;
                    end else begin
                        pulse_next = pulse + CW'(1);
                        state_next = ENT_HI;
                    end
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            WAIT: begin
                if (cnt == CW'(RESULT_WAIT - 1)) begin
                    cnt_next   = '0;
                    state_next = CAPT;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            CAPT: begin
                state_next = CLEAR;
            end
            CLEAR: begin
                if (cnt == CW'(CLR_CYCLES - 1)) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // alu strobes are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            pulse      <= '0;
            winner     <= 1'b0;
            last_grant <= 1'b1;
            res        <= 8'h00;
            alu_in_A   <= 4'h0;
            alu_in_B   <= 4'h0;
            alu_oper   <= 4'h0;
            alu_enter  <= 1'b0;
            alu_rst    <= 1'b1;
            done0      <= 1'b0;
            done1      <= 1'b0;
            err0       <= 1'b0;
            err1       <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            pulse     <= pulse_next;
            alu_enter <= (state_next == ENT_HI);
            alu_rst   <= (state_next == CLEAR);
            done0     <= (state == CAPT) && !winner;
            done1     <= (state == CAPT) && winner;
            err0      <= (state_next == REJ) && !grant_sel;
            err1      <= (state_next == REJ) && grant_sel;
            if (state == IDLE && any_req) begin
                winner   <= grant_sel;
                alu_in_A <= grant_sel ? a1 : a0;
                alu_in_B <= grant_sel ? b1 : b0;
                alu_oper <= grant_op;
            end
            if (state == CAPT) begin
                res <= alu_result;
            end
            if (state == REJ || (state == CLEAR && state_next == IDLE)) begin
                last_grant <= winner;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Scoreboard bench for alu_req_arbiter: a stand-in alu, a round-robin reference model and a monitor.
module tb_alu_req_arbiter;

    typedef struct packed {
        logic       who;
        logic       is_err;
        logic [7:0] res;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       req0 = 1'b0, req1 = 1'b0;
    logic [3:0] a0 = 4'h0, b0 = 4'h0, op0 = 4'h0, a1 = 4'h0, b1 = 4'h0, op1 = 4'h0;
    logic       done0, done1, err0, err1, busy, alu_enter, alu_rst;
    logic [7:0] res;
    logic [7:0] alu_result = 8'h00;
    logic [3:0] alu_in_A, alu_in_B, alu_oper;

    logic       req0_v = 1'b0;
    logic [3:0] a0_v = 4'h0, b0_v = 4'h0, op0_v = 4'h0;
    logic       done0_v, done1_v, err0_v, err1_v, busy_v, alu_enter_v, alu_rst_v;
    logic [7:0] res_v;
    logic [7:0] alu_result_v = 8'h00;
    logic [3:0] alu_in_A_v, alu_in_B_v, alu_oper_v;

    alu_req_arbiter u_dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1), .op0(op0), .op1(op1),
        .done0(done0), .done1(done1), .err0(err0), .err1(err1),
        .res(res), .busy(busy), .alu_in_A(alu_in_A), .alu_in_B(alu_in_B),
        .alu_oper(alu_oper), .alu_enter(alu_enter), .alu_rst(alu_rst),
        .alu_result(alu_result)
    );

    alu_req_arbiter #(.ENTER_HI(2), .RESULT_WAIT(3)) u_dut_v (
        .clk(clk), .rst(rst), .req0(req0_v), .req1(1'b0),
        .a0(a0_v), .a1(4'h0), .b0(b0_v), .b1(4'h0), .op0(op0_v), .op1(4'h0),
        .done0(done0_v), .done1(done1_v), .err0(err0_v), .err1(err1_v),
        .res(res_v), .busy(busy_v), .alu_in_A(alu_in_A_v), .alu_in_B(alu_in_B_v),
        .alu_oper(alu_oper_v), .alu_enter(alu_enter_v), .alu_rst(alu_rst_v),
        .alu_result(alu_result_v)
    );

    function automatic logic [7:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        case (op)
            4'h1:    return 8'(a) + 8'(b);
            4'h2:    return 8'(a) - 8'(b);
            4'h3:    return 8'(a) * 8'(b);
            4'h4:    return 8'(a | b);
            4'hD:    return 8'(a & b);
            default: return {a, b} ^ {4'h0, op};
        endcase
    endfunction

    // Stand-in alu: loads A, B, oper on the first three enter pulses, computes on the fourth.
    int         ecnt = 0, ecnt_v = 0;
    logic       enq = 1'b0, enq_v = 1'b0;
    logic [3:0] la = 4'h0, lb = 4'h0, lop = 4'h0, la_v = 4'h0, lb_v = 4'h0, lop_v = 4'h0;

    always @(posedge clk) begin
        if (alu_rst) begin
            ecnt       <= 0;
            alu_result <= 8'h00;
        end else if (alu_enter && !enq) begin
            case (ecnt)
                0:       la <= alu_in_A;
                1:       lb <= alu_in_B;
                2:       lop <= alu_oper;
                3:       alu_result <= alu_fn(la, lb, lop);
                default: ;
            endcase
            ecnt <= ecnt + 1;
        end
        enq <= alu_enter;
    end

    always @(posedge clk) begin
        if (alu_rst_v) begin
            ecnt_v       <= 0;
            alu_result_v <= 8'h00;
        end else if (alu_enter_v && !enq_v) begin
            case (ecnt_v)
                0:       la_v <= alu_in_A_v;
                1:       lb_v <= alu_in_B_v;
                2:       lop_v <= alu_oper_v;
                3:       alu_result_v <= alu_fn(la_v, lb_v, lop_v);
                default: ;
            endcase
            ecnt_v <= ecnt_v + 1;
        end
        enq_v <= alu_enter_v;
    end

    int         tests = 0;
    int         fails = 0;
    exp_t       exp_q[$];
    logic       ptr_m = 1'b1;
    logic [7:0] res_m = 8'h00;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference model: serves one requester, recording the outcome the spec rules demand.
    task automatic modelServe(input logic who);
        logic [3:0] oa, ob, oo;
        logic       legal;
        oa    = who ? a1 : a0;
        ob    = who ? b1 : b0;
        oo    = who ? op1 : op0;
        legal = (oo != 4'h0) && (oo != 4'hF);
        if (legal) res_m = alu_fn(oa, ob, oo);
        exp_q.push_back('{who: who, is_err: !legal, res: res_m});
        ptr_m = who;
    endtask

    task automatic applyStimulus(input logic r0, input logic r1,
                                 input logic [3:0] ia0, input logic [3:0] ib0, input logic [3:0] io0,
                                 input logic [3:0] ia1, input logic [3:0] ib1, input logic [3:0] io1);
        logic first;
        @(negedge clk);
        a0 = ia0; b0 = ib0; op0 = io0;
        a1 = ia1; b1 = ib1; op1 = io1;
        if (r0 && r1) begin
            first = ~ptr_m;
            modelServe(first);
            modelServe(~first);
        end else if (r0) begin
            modelServe(1'b0);
        end else if (r1) begin
            modelServe(1'b1);
        end
        req0 = r0;
        req1 = r1;
    endtask

    task automatic monitor();
        int   enter_cnt = 0;
        int   n;
        logic prev_en = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) enter_cnt = 0;
            else if (alu_enter && !prev_en) enter_cnt++;
            prev_en = alu_enter;
            if (done0 | done1 | err0 | err1) begin
                n = int'(done0) + int'(done1) + int'(err0) + int'(err1);
                checkOutput("single_event", n, 1);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_event: got done=%b%b err=%b%b expected none", done1, done0, err1, err0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("requester", done1 | err1, e.who);
                    checkOutput("is_err", err0 | err1, e.is_err);
                    checkOutput("res", res, e.res);
                    checkOutput("enter_pulses", enter_cnt, e.is_err ? 0 : 4);
                end
                enter_cnt = 0;
            end
        end
    endtask

    task automatic serve(input int n0, input int n1);
        int c0 = 0, c1 = 0, t = 0;
        while ((req0 || req1) && t < 300) begin
            @(negedge clk);
            t++;
            if (done0 | err0) begin c0++; if (c0 >= n0) req0 = 1'b0; end
            if (done1 | err1) begin c1++; if (c1 >= n1) req1 = 1'b0; end
        end
        if (t >= 300) begin
            tests++;
            fails++;
            $display("[TB] FAIL serve_timeout: got req=%b%b still high expected both dropped", req1, req0);
            req0 = 1'b0;
            req1 = 1'b0;
        end
    endtask

    task automatic waitIdle();
        int n = 0;
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            tests++;
            fails++;
            $display("[TB] FAIL idle_timeout: got busy=%b expected 0", busy);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         k, n, rises, ev, rst_cnt;
        logic       seen, prev;
        logic [1:0] r;
        logic [3:0] o0, o1;

        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_enter", alu_enter, 0);
        checkOutput("rst_alu_rst", alu_rst, 1);
        checkOutput("rst_res", res, 0);
        checkOutput("rst_done_err", {done1, done0, err1, err0}, 0);
        checkOutput("rst_alu_in", {alu_in_A, alu_in_B, alu_oper}, 0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("idle_alu_rst", alu_rst, 0);

        // Tie right after reset: req0 first (9*9), then req1 (15-8).
        applyStimulus(1'b1, 1'b1, 4'd9, 4'd9, 4'h3, 4'd15, 4'd8, 4'h2);
        serve(1, 1);
        checkOutput("tie_final_res", res, 8'h07);
        waitIdle();

        // Single request: 8+2, latency and clear length.
        applyStimulus(1'b1, 1'b0, 4'd8, 4'd2, 4'h1, 4'h0, 4'h0, 4'h0);
        k = int'(cyc);
        n = 0;
        while (done0 !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        req0 = 1'b0;
        checkOutput("latency_default", int'(cyc) - (k + 1), 11);
        checkOutput("add_res", res, 8'h0A);
        rst_cnt = int'(alu_rst);
        repeat (8) begin
            @(negedge clk);
            rst_cnt += int'(alu_rst);
        end
        checkOutput("clear_cycles", rst_cnt, 4);
        waitIdle();

        // req1 stays high over two ops; req0 arriving mid-op takes the second grant.
        @(negedge clk);
        a1 = 4'd1; b1 = 4'd2; op1 = 4'h1;
        modelServe(1'b1);
        req1 = 1'b1;
        repeat (4) @(negedge clk);
        a0 = 4'd5; b0 = 4'd6; op0 = 4'h4;
        modelServe(1'b0);
        modelServe(1'b1);
        req0 = 1'b1;
        serve(1, 2);
        waitIdle();

        // Illegal opcodes leave the alu untouched.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b0, 4'd3, 4'd3, (i == 0) ? 4'h0 : 4'hF, 4'h0, 4'h0, 4'h0);
            seen = 1'b0;
            ev   = 0;
            repeat (6) begin
                @(negedge clk);
                seen |= alu_enter | alu_rst;
                if (err0) begin
                    ev++;
                    req0 = 1'b0;
                end
            end
            checkOutput("illegal_alu_quiet", seen, 0);
            checkOutput("illegal_err_pulses", ev, 1);
            checkOutput("illegal_res_kept", res, res_m);
            waitIdle();
        end

        // Randomised traffic against the reference model.
        for (int i = 0; i < 25; i++) begin
            r  = 2'($urandom_range(1, 3));
            o0 = 4'($urandom_range(0, 15));
            o1 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 4) == 0) o0 = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'hF;
            applyStimulus(r[0], r[1], 4'($urandom), 4'($urandom), o0, 4'($urandom), 4'($urandom), o1);
            serve(1, 1);
            waitIdle();
        end

        // Reset during the third enter pulse aborts the operation.
        @(negedge clk);
        a0 = 4'd4; b0 = 4'd4; op0 = 4'h1;
        req0  = 1'b1;
        rises = 0;
        prev  = 1'b0;
        n     = 0;
        while (rises < 3 && n < 30) begin
            @(negedge clk);
            n++;
            if (alu_enter && !prev) rises++;
            prev = alu_enter;
        end
        checkOutput("third_pulse_seen", rises, 3);
        rst  = 1'b0;
        req0 = 1'b0;
        @(negedge clk);
        checkOutput("abort_enter", alu_enter, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_alu_rst", alu_rst, 1);
        checkOutput("abort_res", res, 0);
        rst   = 1'b1;
        ptr_m = 1'b1;
        res_m = 8'h00;
        ev    = 0;
        repeat (15) begin
            @(negedge clk);
            ev += int'(done0) + int'(err0) + int'(done1) + int'(err1);
        end
        checkOutput("abort_no_event", ev, 0);
        applyStimulus(1'b1, 1'b1, 4'd2, 4'd3, 4'h3, 4'd7, 4'd1, 4'h1);
        serve(1, 1);
        waitIdle();

        // Variant timing build: ENTER_HI=2, RESULT_WAIT=3, 4'hD & 4'h7.
        @(negedge clk);
        a0_v = 4'hD; b0_v = 4'h7; op0_v = 4'hD;
        req0_v = 1'b1;
        k = int'(cyc);
        n = 0;
        while (done0_v !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        req0_v = 1'b0;
        checkOutput("latency_variant", int'(cyc) - (k + 1), 16);
        checkOutput("and_res_variant", res_v, 8'h05);

        repeat (10) @(negedge clk);
        checkOutput("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
